addr_calc_datapath: RTL and testbench



---
 rtl/addr_calc_datapath_if.sv | 44 ++++
 rtl/addr_calc_datapath.sv | 63 ++++++
 tb/tb_addr_calc_datapath.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_calc_datapath_if.sv
// Bus interface between the MR CPU control/register-file side and the address datapath.
// Carry outputs exist only when ADDR_CARRY_EN is defined.
interface addr_calc_datapath_if #(
    parameter int IR_W   = 16,
    parameter int ADDR_W = 8
);
    logic [IR_W-1:0]   ir_in;
    logic [IR_W-1:0]   regb_out;
    logic              ld_ir;
    logic              ld_rdir;
    logic              ld_pc;
    logic              mux_1_pc;
    logic              reset_pc_sel;
    logic [IR_W-1:0]   ir_out;
    logic [ADDR_W-1:0] rdir_out;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] add_dir_out;
    logic [ADDR_W-1:0] inc_out;
    logic [ADDR_W-1:0] mux_1_out;
`ifdef ADDR_CARRY_EN
    logic              dir_carry;
    logic              inc_carry;

    modport master (
        output ir_in, regb_out, ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel,
        input  ir_out, rdir_out, pc_out, add_dir_out, inc_out, mux_1_out,
        input  dir_carry, inc_carry
    );
    modport slave (
        input  ir_in, regb_out, ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel,
        output ir_out, rdir_out, pc_out, add_dir_out, inc_out, mux_1_out,
        output dir_carry, inc_carry
    );
`else
    modport master (
        output ir_in, regb_out, ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel,
        input  ir_out, rdir_out, pc_out, add_dir_out, inc_out, mux_1_out
    );
    modport slave (
        input  ir_in, regb_out, ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel,
        output ir_out, rdir_out, pc_out, add_dir_out, inc_out, mux_1_out
    );
`endif
endinterface

// File: rtl/addr_calc_datapath.sv
// MR CPU address datapath: IR, effective-address register RDIR and PC with their adders/mux.
// Optional macro ADDR_CARRY_EN exposes the carry-outs of both adders.
module addr_calc_datapath #(
    parameter int IR_W   = 16,
    parameter int ADDR_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    addr_calc_datapath_if.slave bus
);
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0] rdir_q, rdir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mux_1;
    logic [ADDR_W:0]   dir_sum;
    logic [ADDR_W:0]   inc_sum;

    // One extra bit on each adder holds the carry-out; the address itself wraps.
    assign dir_sum = {1'b0, bus.regb_out[ADDR_W-1:0]} + {1'b0, ir_q[ADDR_W-1:0]};
    assign mux_1   = bus.mux_1_pc ? rdir_q : pc_q;
    assign inc_sum = {1'b0, mux_1} + (ADDR_W+1)'(1);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        ir_d   = ir_q;
        rdir_d = rdir_q;
        pc_d   = pc_q;
        if (bus.ld_ir)   ir_d   = bus.ir_in;
        if (bus.ld_rdir) rdir_d = dir_sum[ADDR_W-1:0];
        if (bus.ld_pc)   pc_d   = bus.reset_pc_sel ? '0 : inc_sum[ADDR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q   <= '0;
            rdir_q <= '0;
            pc_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            ir_q   <= ir_d;
            rdir_q <= rdir_d;
            pc_q   <= pc_d;
        end
    end

    assign bus.ir_out      = ir_q;
    assign bus.rdir_out    = rdir_q;
    assign bus.pc_out      = pc_q;
    assign bus.add_dir_out = dir_sum[ADDR_W-1:0];
    assign bus.mux_1_out   = mux_1;
    assign bus.inc_out     = inc_sum[ADDR_W-1:0];

`ifdef ADDR_CARRY_EN
    assign bus.dir_carry = dir_sum[ADDR_W];
    assign bus.inc_carry = inc_sum[ADDR_W];

    logic unused_bits;
    assign unused_bits = ^bus.regb_out[IR_W-1:ADDR_W];
`else
    logic unused_bits;
    assign unused_bits = ^{bus.regb_out[IR_W-1:ADDR_W], dir_sum[ADDR_W], inc_sum[ADDR_W]};
`endif
endmodule

// File: tb/tb_addr_calc_datapath.sv
// Self-checking bench for addr_calc_datapath: directed vector table, corner sequences, random vs model.
module tb_addr_calc_datapath;
    localparam int IR_W   = 16;
    localparam int ADDR_W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    addr_calc_datapath_if #(.IR_W(IR_W), .ADDR_W(ADDR_W)) bus ();

    addr_calc_datapath #(.IR_W(IR_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    // Reference state: architectural register contents, updated per edge with plain arithmetic.
    int ir_m, rdir_m, pc_m;

    function automatic int m_sel();
        return bus.mux_1_pc ? rdir_m : pc_m;
    endfunction

    function automatic int m_add_full();
        return (int'(bus.regb_out) % 256) + (ir_m % 256);
    endfunction

    task automatic model_edge();
        int nir, nrdir, npc;
        nir   = bus.ld_ir   ? int'(bus.ir_in) : ir_m;
        nrdir = bus.ld_rdir ? m_add_full() % 256 : rdir_m;
        npc   = !bus.ld_pc ? pc_m : (bus.reset_pc_sel ? 0 : (m_sel() + 1) % 256);
        ir_m  = nir;
        rdir_m = nrdir;
        pc_m  = npc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ir"},   32'(bus.ir_out),      32'(ir_m));
        check({tag, ".rdir"}, 32'(bus.rdir_out),    32'(rdir_m));
        check({tag, ".pc"},   32'(bus.pc_out),      32'(pc_m));
        check({tag, ".add"},  32'(bus.add_dir_out), 32'(m_add_full() % 256));
        check({tag, ".mux"},  32'(bus.mux_1_out),   32'(m_sel()));
        check({tag, ".inc"},  32'(bus.inc_out),     32'((m_sel() + 1) % 256));
`ifdef ADDR_CARRY_EN
        check({tag, ".dcy"},  32'(bus.dir_carry),   32'(m_add_full() >= 256));
        check({tag, ".icy"},  32'(bus.inc_carry),   32'(m_sel() == 255));
`endif
    endtask

    // Advance one rising edge, keep the model in step, sample 1 ns later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ir_in, input logic [15:0] regb,
                         input logic ld_ir, input logic ld_rdir, input logic ld_pc,
                         input logic mux, input logic rsel);
        bus.ir_in        = ir_in;
        bus.regb_out     = regb;
        bus.ld_ir        = ld_ir;
        bus.ld_rdir      = ld_rdir;
        bus.ld_pc        = ld_pc;
        bus.mux_1_pc     = mux;
        bus.reset_pc_sel = rsel;
    endtask

    typedef struct {
        logic [15:0] ir_in;
        logic [15:0] regb;
        logic        ld_ir, ld_rdir, ld_pc, mux, rsel;
        logic [15:0] e_ir;
        logic [7:0]  e_rdir, e_pc, e_add, e_mux, e_inc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ir_m = 0; rdir_m = 0; pc_m = 0;

        //          ir_in     regb     ir rd pc mx rs   e_ir     rdir   pc     add    mux    inc
        vecs[0] = '{16'hFFAA, 16'h0000, 1, 0, 1, 0, 1, 16'hFFAA, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h01};
        vecs[1] = '{16'h0000, 16'h0010, 0, 1, 1, 0, 0, 16'hFFAA, 8'hBA, 8'h01, 8'hBA, 8'h01, 8'h02};
        vecs[2] = '{16'h0000, 16'h0010, 0, 1, 1, 0, 0, 16'hFFAA, 8'hBA, 8'h02, 8'hBA, 8'h02, 8'h03};
        vecs[3] = '{16'h0000, 16'h0010, 0, 1, 1, 0, 0, 16'hFFAA, 8'hBA, 8'h03, 8'hBA, 8'h03, 8'h04};
        vecs[4] = '{16'h0000, 16'h0010, 0, 0, 1, 1, 0, 16'hFFAA, 8'hBA, 8'hBB, 8'hBA, 8'hBA, 8'hBB};
        vecs[5] = '{16'h0000, 16'h0010, 0, 0, 1, 0, 0, 16'hFFAA, 8'hBA, 8'hBC, 8'hBA, 8'hBC, 8'hBD};
        // IR and RDIR loaded together: RDIR captures the old displacement 0xAA.
        vecs[6] = '{16'h1280, 16'h0080, 1, 1, 0, 0, 0, 16'h1280, 8'h2A, 8'hBC, 8'h00, 8'hBC, 8'hBD};

        rst = 1'b1;
        drive(16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        #3;
        check("reset.ir",   32'(bus.ir_out),   32'h0);
        check("reset.rdir", 32'(bus.rdir_out), 32'h0);
        check("reset.pc",   32'(bus.pc_out),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].ir_in, vecs[i].regb, vecs[i].ld_ir, vecs[i].ld_rdir,
                  vecs[i].ld_pc, vecs[i].mux, vecs[i].rsel);
            tick();
            check($sformatf("vec%0d.ir", i),   32'(bus.ir_out),      32'(vecs[i].e_ir));
            check($sformatf("vec%0d.rdir", i), 32'(bus.rdir_out),    32'(vecs[i].e_rdir));
            check($sformatf("vec%0d.pc", i),   32'(bus.pc_out),      32'(vecs[i].e_pc));
            check($sformatf("vec%0d.add", i),  32'(bus.add_dir_out), 32'(vecs[i].e_add));
            check($sformatf("vec%0d.mux", i),  32'(bus.mux_1_out),   32'(vecs[i].e_mux));
            check($sformatf("vec%0d.inc", i),  32'(bus.inc_out),     32'(vecs[i].e_inc));
        end
`ifdef ADDR_CARRY_EN
        check("vec6.dir_carry", 32'(bus.dir_carry), 32'h1);
`endif

        // PC wrap: RDIR <- 0x7E+0x80, PC <- RDIR+1 = 0xFF, then PC+1 wraps to 0x00.
        drive(16'h0000, 16'h007E, 0, 1, 0, 0, 0);
        tick();
        check("wrap.rdir", 32'(bus.rdir_out), 32'hFE);
        drive(16'h0000, 16'h007E, 0, 0, 1, 1, 0);
        tick();
        check("wrap.pc_ff", 32'(bus.pc_out), 32'hFF);
        bus.mux_1_pc = 1'b0;
        #1;
        check("wrap.inc_comb", 32'(bus.inc_out), 32'h00);
`ifdef ADDR_CARRY_EN
        check("wrap.inc_carry", 32'(bus.inc_carry), 32'h1);
`endif
        tick();
        check("wrap.pc_00", 32'(bus.pc_out), 32'h00);
        tick();
        check("wrap.pc_01", 32'(bus.pc_out), 32'h01);

        // Hold: no loads while ir_in and regb_out change.
        for (int i = 0; i < 5; i++) begin
            drive(16'($urandom), 16'($urandom), 0, 0, 0, 1'($urandom), 0);
            tick();
            check($sformatf("hold%0d.ir", i),   32'(bus.ir_out),   32'h1280);
            check($sformatf("hold%0d.rdir", i), 32'(bus.rdir_out), 32'hFE);
            check($sformatf("hold%0d.pc", i),   32'(bus.pc_out),   32'h01);
        end
        drive(16'h0000, 16'h0000, 0, 0, 1, 0, 1);
        tick();
        check("sync_clear.pc", 32'(bus.pc_out), 32'h00);
        drive(16'h0000, 16'h0000, 0, 0, 1, 1, 0);
        tick();
        check("pre_rst.pc", 32'(bus.pc_out), 32'hFF);

        // Asynchronous reset mid-cycle, then held across an edge with loads active.
        drive(16'h5555, 16'h0033, 1, 1, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.ir",   32'(bus.ir_out),   32'h0);
        check("async_rst.rdir", 32'(bus.rdir_out), 32'h0);
        check("async_rst.pc",   32'(bus.pc_out),   32'h0);
        @(posedge clk);
        #1;
        check("rst_prio.ir",   32'(bus.ir_out),   32'h0);
        check("rst_prio.rdir", 32'(bus.rdir_out), 32'h0);
        check("rst_prio.pc",   32'(bus.pc_out),   32'h0);
        #3;
        rst = 1'b0;
        ir_m = 0; rdir_m = 0; pc_m = 0;
        tick();
        check_model("post_rst");

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
